instr_fetch: RTL

Instruction fetch stage for the single-issue MIPS datapath: owns the program counter, issues word reads to instruction memory, buffers returned words with their PCs, and presents them to the decode stage through a valid/ready handshake. Its `id_opcode` output drives the `OpCode` input of the control decoder; `id_instr` feeds the register-file and immediate fields. A branch/jump redirect flushes all buffered and in-flight fetches.

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/instr_fetch.sv | 77 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: instruction geometry, PC step and the
// opcode encodings that the fetch stage and the control decoder agree on.
package mips_pkg;
  localparam int          INSTR_W  = 32;
  localparam int          OPCODE_W = 6;
  localparam logic [31:0] PC_STEP  = 32'd4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for {pc, instr} pairs. Flush empties it in one cycle;
// storage is reset so the head reads as zero out of reset.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wdata;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-based imem requests (1-cycle memory), and a
// prefetch FIFO presented to decode via valid/ready. Redirect flushes everything.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [31:0]         id_pc,
  output logic [OPCODE_W-1:0] id_opcode
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_L = CW1'(DEPTH);

  logic                   started, inflight, kill;
  logic [31:0]            pc, req_pc;
  logic                   pop, push, fifo_empty, fifo_full;
  logic [CW-1:0]          count;
  logic [CW:0]            occ, lim;
  logic [32+INSTR_W-1:0]  head;

  assign id_valid = ~fifo_empty;
  assign pop      = id_valid & id_ready;
  // A response from a request issued during a redirect window is never kept.
  assign push     = inflight & ~kill;

  // Credit: buffered + in-flight, less what leaves this cycle, must stay below DEPTH.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign lim      = DEPTH_L + {{CW{1'b0}}, pop};
  assign imem_req = started & ~redirect & ~(fifo_full & ~pop) & (occ < lim);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      started  <= 1'b0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      started  <= 1'b1;
      inflight <= imem_req;
      kill     <= redirect;
      if (imem_req) req_pc <= pc;
      if (redirect)      pc <= redirect_pc & ~32'h3;
      else if (imem_req) pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(.WIDTH(32 + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_pc, imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .rdata (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign id_pc     = head[32+INSTR_W-1:INSTR_W];
  assign id_instr  = head[INSTR_W-1:0];
  assign id_opcode = id_instr[INSTR_W-1:INSTR_W-OPCODE_W];
endmodule
